// File: rtl/maquina_lectura.sv
// Read-side RTC sequencer: walks the ten RTC registers, masks each byte to its
// field width and writes it into the local display/edit bank at index 1-10.
// The completion pulse is named finalizado because "final" is a reserved word.
module maquina_lectura #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       fin,
  input  logic [7:0] dato_in,
  output logic       lee,
  output logic [7:0] dir_out,
  output logic [3:0] addr,
  output logic [7:0] dato_out,
  output logic       escribe,
  output logic       finalizado,
  output logic       error,
  output logic       ocupado
);

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;
  localparam int unsigned TW = 8;
  localparam logic [AW-1:0] FIRST = AW'(1);
  localparam logic [AW-1:0] LAST  = AW'(10);
  localparam logic [TW-1:0] TIMER_LIMIT = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_STORE = 3'd3,
    S_NEXT  = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  state_t          state, state_d;
  logic [AW-1:0]   contador, contador_d;
  logic [TW-1:0]   timer, timer_d;
  logic [DW-1:0]   dir_d, dato_d;
  logic [AW-1:0]   addr_d;
  logic            error_d;

  // RTC address for each bank index; indices outside 1-10 read address 0.
  function automatic logic [DW-1:0] map_dir(input logic [AW-1:0] idx);
    logic [DW-1:0] d;
    case (idx)
      4'd1:    d = 8'h21;
      4'd2:    d = 8'h22;
      4'd3:    d = 8'h23;
      4'd4:    d = 8'h24;
      4'd5:    d = 8'h25;
      4'd6:    d = 8'h26;
      4'd7:    d = 8'h27;
      4'd8:    d = 8'h41;
      4'd9:    d = 8'h42;
      4'd10:   d = 8'h43;
      default: d = 8'h00;
    endcase
    return d;
  endfunction

  // Valid field width of each RTC register.
  function automatic logic [DW-1:0] map_mask(input logic [AW-1:0] idx);
    logic [DW-1:0] m;
    case (idx)
      4'd1, 4'd2, 4'd8, 4'd9: m = 8'h7F;
      4'd3, 4'd4, 4'd10:      m = 8'h3F;
      4'd5:                   m = 8'h1F;
      4'd6, 4'd7:             m = 8'hFF;
      default:                m = 8'h00;
    endcase
    return m;
  endfunction

  // Next-state and register-transfer logic.
  always_comb begin
    state_d    = state;
    contador_d = contador;
    timer_d    = timer;
    dir_d      = dir_out;
    addr_d     = addr;
    dato_d     = dato_out;
    error_d    = error;
    case (state)
      S_IDLE: begin
        if (iniciar) begin
          state_d    = S_REQ;
          contador_d = FIRST;
          error_d    = 1'b0;
          timer_d    = '0;
        end
      end
      S_REQ: begin
        dir_d   = map_dir(contador);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = TW'(timer + 1'b1);
        if (fin) begin
          state_d = S_STORE;
          dato_d  = dato_in & map_mask(contador);
          addr_d  = contador;
        end else if (timer == TIMER_LIMIT) begin
          state_d = S_ERR;
        end
      end
      S_STORE: state_d = S_NEXT;
      S_NEXT: begin
        timer_d = '0;
        if (contador == LAST) begin
          state_d = S_DONE;
        end else begin
          contador_d = AW'(contador + 1'b1);
          state_d    = S_REQ;
        end
      end
      S_DONE: begin
        dir_d      = '0;
        addr_d     = '0;
        dato_d     = '0;
        contador_d = FIRST;
        state_d    = S_IDLE;
      end
      S_ERR: begin
        error_d    = 1'b1;
        dir_d      = '0;
        addr_d     = '0;
        dato_d     = '0;
        contador_d = FIRST;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and strobes; strobes are decoded from the next state so
  // they are visible during the state they belong to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      contador   <= FIRST;
      timer      <= '0;
      dir_out    <= '0;
      addr       <= '0;
      dato_out   <= '0;
      error      <= 1'b0;
      lee        <= 1'b0;
      escribe    <= 1'b0;
      finalizado <= 1'b0;
      ocupado    <= 1'b0;
    end else begin
      state      <= state_d;
      contador   <= contador_d;
      timer      <= timer_d;
      dir_out    <= dir_d;
      addr       <= addr_d;
      dato_out   <= dato_d;
      error      <= error_d;
      lee        <= (state_d == S_WAIT);
      escribe    <= (state_d == S_STORE);
      finalizado <= (state_d == S_DONE);
      ocupado    <= (state_d != S_IDLE);
    end
  end

endmodule

// File: tb/tb_maquina_lectura.sv
// Directed bench for maquina_lectura: full reads, zero-wait, timeout,
// ignored fin/iniciar and asynchronous reset mid-sequence.
module tb_maquina_lectura;

  logic       clk;
  logic       reset;
  logic       iniciar;
  logic       fin;
  logic [7:0] dato_in;
  logic       lee;
  logic [7:0] dir_out;
  logic [3:0] addr;
  logic [7:0] dato_out;
  logic       escribe;
  logic       finalizado;
  logic       error;
  logic       ocupado;

  maquina_lectura #(.TIMEOUT(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .iniciar    (iniciar),
    .fin        (fin),
    .dato_in    (dato_in),
    .lee        (lee),
    .dir_out    (dir_out),
    .addr       (addr),
    .dato_out   (dato_out),
    .escribe    (escribe),
    .finalizado (finalizado),
    .error      (error),
    .ocupado    (ocupado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_dir  [0:9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25,
                                 8'h26, 8'h27, 8'h41, 8'h42, 8'h43};
  logic [7:0] exp_mask [0:9] = '{8'h7F, 8'h7F, 8'h3F, 8'h3F, 8'h1F,
                                 8'hFF, 8'hFF, 8'h7F, 8'h7F, 8'h3F};

  // Recorded bank writes and strobes.
  logic [3:0] ev_addr [0:15];
  logic [7:0] ev_dir  [0:15];
  logic [7:0] ev_dato [0:15];
  int n_ev, n_final, final_cyc, lee_run, lee_max, cyc;

  // fin responder: 0 low, 1 tied high, 2 k cycles after lee rises, 3 as 2 plus noise outside WAIT.
  int fin_mode = 0;
  int k = 0;
  int stop_after = 99;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_rec();
    n_ev = 0; n_final = 0; final_cyc = 0; lee_run = 0; lee_max = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (escribe) begin
      if (n_ev < 16) begin
        ev_addr[n_ev] = addr;
        ev_dir[n_ev]  = dir_out;
        ev_dato[n_ev] = dato_out;
      end
      n_ev++;
    end
    if (finalizado) begin
      n_final++;
      final_cyc = cyc;
    end
    if (lee) begin
      lee_run++;
      if (lee_run > lee_max) lee_max = lee_run;
    end else begin
      lee_run = 0;
    end
    case (fin_mode)
      1:       fin = 1'b1;
      2:       fin = lee && (lee_run == k + 1) && (n_ev < stop_after);
      3:       fin = (lee && (lee_run == k + 1)) || (!lee && ocupado);
      default: fin = 1'b0;
    endcase
  endtask

  task automatic start();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
  endtask

  initial begin
    int start_cyc;
    bit reached;
    reset = 1'b0; iniciar = 1'b0; fin = 1'b0; dato_in = 8'h00; cyc = 0;
    clear_rec();

    // Reset state with the clock running.
    repeat (3) tick();
    check("rst_lee", lee, 0);
    check("rst_escribe", escribe, 0);
    check("rst_final", finalizado, 0);
    check("rst_error", error, 0);
    check("rst_ocupado", ocupado, 0);
    check("rst_dir", dir_out, 0);
    check("rst_addr", addr, 0);
    check("rst_dato", dato_out, 0);
    reset = 1'b1;
    repeat (3) tick();
    check("idle_ocupado", ocupado, 0);

    // Full read, fin two cycles after lee, iniciar dropped after acceptance.
    clear_rec();
    fin_mode = 2; k = 2; stop_after = 99; dato_in = 8'hFF;
    start();
    check("busy_after_start", ocupado, 1);
    repeat (75) tick();
    check("full_nwrites", n_ev, 10);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("full_addr%0d", i), ev_addr[i], 32'(i + 1));
      check($sformatf("full_dir%0d", i), ev_dir[i], exp_dir[i]);
      check($sformatf("full_dato%0d", i), ev_dato[i], exp_mask[i]);
    end
    check("full_final", n_final, 1);
    check("full_error", error, 0);
    check("full_idle", ocupado, 0);

    // Zero-wait: fin tied high, also present in REQ/STORE/NEXT.
    clear_rec();
    fin_mode = 1; fin = 1'b1; dato_in = 8'hA5;
    start_cyc = cyc;
    start();
    repeat (55) tick();
    fin_mode = 0; fin = 1'b0;
    check("zw_nwrites", n_ev, 10);
    check("zw_final", n_final, 1);
    check("zw_latency", final_cyc - start_cyc, 41);
    check("zw_addr10", ev_addr[9], 10);
    check("zw_dato5", ev_dato[4], 8'h05);
    check("zw_dato6", ev_dato[5], 8'hA5);
    check("zw_dato3", ev_dato[2], 8'h25);

    // Timeout on the third location.
    clear_rec();
    fin_mode = 2; k = 0; stop_after = 2; dato_in = 8'h3C;
    start();
    repeat (40) tick();
    check("to_nwrites", n_ev, 2);
    check("to_addr2", ev_addr[1], 2);
    check("to_dir2", ev_dir[1], 8'h22);
    check("to_lee_len", lee_max, 8);
    check("to_error", error, 1);
    check("to_nofinal", n_final, 0);
    check("to_idle", ocupado, 0);

    // New start clears error; fin noise outside WAIT must not add writes.
    clear_rec();
    fin_mode = 3; k = 1; dato_in = 8'hFF;
    start();
    check("err_cleared", error, 0);
    repeat (70) tick();
    check("noise_nwrites", n_ev, 10);
    check("noise_final", n_final, 1);
    check("noise_dato10", ev_dato[9], 8'h3F);
    check("noise_error", error, 0);

    // Asynchronous reset while waiting on location 5.
    clear_rec();
    fin_mode = 2; k = 3; stop_after = 99;
    start();
    reached = 1'b0;
    for (int i = 0; i < 60 && !reached; i++) begin
      tick();
      if (n_ev == 4 && lee) reached = 1'b1;
    end
    check("arst_reached_wait5", reached, 1);
    check("arst_dir5", dir_out, 8'h25);
    #1 reset = 1'b0;
    #1;
    check("arst_lee", lee, 0);
    check("arst_ocupado", ocupado, 0);
    check("arst_dir", dir_out, 0);
    fin_mode = 0; fin = 1'b0;
    tick();
    reset = 1'b1;
    repeat (3) tick();
    check("arst_stays_idle", ocupado, 0);
    fin_mode = 2; k = 0;
    start();
    tick();
    check("restart_lee", lee, 1);
    check("restart_dir", dir_out, 8'h21);
    repeat (45) tick();
    check("restart_final", n_final, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
